// File: rtl/tape_pkg.sv
// State encoding and fixed byte values shared by the CAS tape player.
package tape_pkg;

  typedef logic [2:0] tape_state_t;

  localparam tape_state_t IDLE   = 3'd0;
  localparam tape_state_t LEADER = 3'd1;
  localparam tape_state_t FETCH  = 3'd2;
  localparam tape_state_t CELL   = 3'd3;
  localparam tape_state_t PAUSE  = 3'd4;
  localparam tape_state_t FINISH = 3'd5;

  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam logic [7:0] LEADER_BYTE = 8'h00;

endpackage

// File: rtl/tape_cas_player_bit_cell.sv
// One 500-baud bit cell: clock pulse at phase 0, data pulse at mid-cell, registered output.
// A cell may only begin (leave phase 0) while motor_i is high; once begun it always completes.
module tape_bit_cell
  import tape_pkg::*;
#(
  parameter int unsigned BIT_CYCLES   = 84000,
  parameter int unsigned PULSE_CYCLES = 5250
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic go_i,
  input  logic bit_i,
  input  logic motor_i,
  output logic tape_o,
  output logic cell_end_o
);

  localparam int unsigned PW = $clog2(BIT_CYCLES);
  localparam logic [PW-1:0] PH_LAST  = PW'(BIT_CYCLES - 1);
  localparam logic [PW-1:0] PH_HALF  = PW'(BIT_CYCLES / 2);
  localparam logic [PW-1:0] PH_PULSE = PW'(PULSE_CYCLES);
  localparam logic [PW-1:0] PH_DEND  = PW'(BIT_CYCLES / 2 + PULSE_CYCLES);
  localparam logic [PW-1:0] PH_ONE   = PW'(1);

  logic [PW-1:0] ph_q, ph_d;
  logic          tape_q, tape_d;
  logic          run;

  // Phase 0 doubles as the wait point while the motor is off.
  assign run        = go_i && ((ph_q != '0) || motor_i);
  assign cell_end_o = run && (ph_q == PH_LAST);
  assign tape_o     = tape_q;

  always_comb begin
    ph_d   = '0;
    tape_d = 1'b0;
    if (run) begin
      ph_d = cell_end_o ? '0 : ph_q + PH_ONE;
      if (ph_q < PH_PULSE) begin
        tape_d = 1'b1;
      end else if ((ph_q >= PH_HALF) && (ph_q < PH_DEND)) begin
        tape_d = bit_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ph_q   <= '0;
      tape_q <= 1'b0;
    end else begin
      ph_q   <= ph_d;
      tape_q <= tape_d;
    end
  end

endmodule

// File: rtl/tape_cas_player.sv
// CAS byte stream to TRS-80 Level II 500-baud pulse code, MSB first, motor-gated.
// TAPE_CAS_LEADER_EN: start first plays LEADER_BYTES x 0x00 and a 0xA5 sync byte with no handshake.
module tape_cas_player
  import tape_pkg::*;
#(
  parameter int unsigned BIT_CYCLES   = 84000,
  parameter int unsigned PULSE_CYCLES = 5250
`ifdef TAPE_CAS_LEADER_EN
  ,
  parameter int unsigned LEADER_BYTES = 256
`endif
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic       motor_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic [7:0] in_data_i,
  input  logic       in_last_i,
  output logic       tape_out_o,
  output logic       busy_o,
  output logic       done_o
);

  tape_state_t state_q, state_d;
  logic [7:0]  sh_q, sh_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic        lst_q, lst_d;
  logic        hs, go, cell_end;

`ifdef TAPE_CAS_LEADER_EN
  localparam int unsigned LW = $clog2(LEADER_BYTES + 1);
  logic [LW-1:0] ldr_q, ldr_d;
`endif

  assign in_ready_o = (state_q == FETCH);
  assign hs         = in_valid_i && in_ready_o;
  assign busy_o     = (state_q != IDLE);
  assign done_o     = (state_q == FINISH);

`ifdef TAPE_CAS_LEADER_EN
  assign go = !abort_i && ((state_q == CELL) || (state_q == LEADER));
`else
  assign go = !abort_i && (state_q == CELL);
`endif

  tape_bit_cell #(
    .BIT_CYCLES  (BIT_CYCLES),
    .PULSE_CYCLES(PULSE_CYCLES)
  ) u_cell (
    .clk_i     (clk_i),
    .rst_i     (reset_i),
    .go_i      (go),
    .bit_i     (sh_q[7]),
    .motor_i   (motor_i),
    .tape_o    (tape_out_o),
    .cell_end_o(cell_end)
  );

  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    bitcnt_d = bitcnt_q;
    lst_d    = lst_q;
`ifdef TAPE_CAS_LEADER_EN
    ldr_d    = ldr_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_i) begin
`ifdef TAPE_CAS_LEADER_EN
          state_d  = LEADER;
          sh_d     = LEADER_BYTE;
          bitcnt_d = 3'd7;
          lst_d    = 1'b0;
          ldr_d    = LW'(LEADER_BYTES);
`else
          state_d  = FETCH;
`endif
        end
      end
      FETCH: begin
        if (hs) begin
          sh_d     = in_data_i;
          lst_d    = in_last_i;
          bitcnt_d = 3'd7;
          state_d  = motor_i ? CELL : PAUSE;
        end
      end
      CELL: begin
        if (cell_end) begin
          if (bitcnt_q != 3'd0) begin
            sh_d     = {sh_q[6:0], 1'b0};
            bitcnt_d = bitcnt_q - 3'd1;
            if (!motor_i) state_d = PAUSE;
          end else if (lst_q) begin
            state_d = FINISH;
          end else begin
            state_d = FETCH;
          end
        end
      end
      PAUSE: begin
        if (motor_i) state_d = CELL;
      end
`ifdef TAPE_CAS_LEADER_EN
      // ldr_q counts bytes still to play after the current one; the last of them is the sync byte.
      LEADER: begin
        if (cell_end) begin
          if (bitcnt_q != 3'd0) begin
            sh_d     = {sh_q[6:0], 1'b0};
            bitcnt_d = bitcnt_q - 3'd1;
          end else if (ldr_q != '0) begin
            sh_d     = (ldr_q == LW'(1)) ? SYNC_BYTE : LEADER_BYTE;
            bitcnt_d = 3'd7;
            ldr_d    = ldr_q - LW'(1);
          end else begin
            state_d = FETCH;
          end
        end
      end
`endif
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_i) state_d = IDLE;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      sh_q     <= 8'h00;
      bitcnt_q <= 3'd0;
      lst_q    <= 1'b0;
`ifdef TAPE_CAS_LEADER_EN
      ldr_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      bitcnt_q <= bitcnt_d;
      lst_q    <= lst_d;
`ifdef TAPE_CAS_LEADER_EN
      ldr_q    <= ldr_d;
`endif
    end
  end

endmodule

// File: tb/tb_tape_cas_player.sv
// Directed bench: expected bits queued as bytes are offered, decoded back from tape_out and compared.
module tb_tape_cas_player;

  localparam int BC = 16;
  localparam int PC = 2;
`ifdef TAPE_CAS_LEADER_EN
  localparam int LC = 24;
`else
  localparam int LC = 0;
`endif

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } src_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       motor = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic       in_ready, tape, busy, done;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  src_t src_q[$];
  logic exp_bits[$];
  int   rises[$];
  logic hs_pend = 1'b0;
  int   hs_cnt = 0, rdy_cnt = 0, rdy_first = -1;
  int   done_cnt = 0, done_cyc = -1, busy_fall = -1;
  logic busy_prev = 1'b0, tp_prev = 1'b0, dec_act = 1'b0;
  int   rc = 0;
  logic [4:0] shp = 5'd0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tape_cas_player #(
    .BIT_CYCLES  (BC),
    .PULSE_CYCLES(PC)
`ifdef TAPE_CAS_LEADER_EN
    ,
    .LEADER_BYTES(2)
`endif
  ) dut (
    .clk_i     (clk),
    .reset_i   (reset),
    .start_i   (start),
    .abort_i   (abort),
    .motor_i   (motor),
    .in_valid_i(in_valid),
    .in_ready_o(in_ready),
    .in_data_i (in_data),
    .in_last_i (in_last),
    .tape_out_o(tape),
    .busy_o    (busy),
    .done_o    (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    vectors++;
    assert (obs === req) else begin
      miscompares++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, req);
    end
  endtask

  // Byte source: the handshake decided before a posedge is retired at the following negedge.
  always @(negedge clk) begin
    if (hs_pend && src_q.size() > 0) void'(src_q.pop_front());
    in_valid = (src_q.size() > 0);
    in_data  = 8'h00;
    in_last  = 1'b0;
    if (in_valid) begin
      in_data = src_q[0].d;
      in_last = src_q[0].l;
    end
    hs_pend = in_valid && in_ready;
    if (hs_pend) hs_cnt++;
    if (in_ready) begin
      rdy_cnt++;
      if (rdy_first < 0) rdy_first = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy_prev && !busy) busy_fall = cyc;
    busy_prev = busy;
  end

  // Cell decoder: a clock-pulse rise opens a cell; sample pulse shape and the mid-cell data pulse.
  always @(negedge clk) begin
    if (dec_act) begin
      case (cyc - rc)
        1: shp[4] = tape;
        2: shp[3] = tape;
        8: shp[2] = tape;
        9: shp[1] = tape;
        10: begin
          logic b;
          shp[0]  = tape;
          dec_act = 1'b0;
          check("bit_expected", 32'(exp_bits.size() != 0), 32'd1);
          if (exp_bits.size() != 0) begin
            b = exp_bits.pop_front();
            check("cell_shape", 32'(shp), 32'({1'b1, 1'b0, b, b, 1'b0}));
          end
        end
        default: ;
      endcase
    end else if (tape && !tp_prev) begin
      dec_act = 1'b1;
      rc      = cyc;
      rises.push_back(cyc);
    end
    tp_prev = tape;
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic flush();
    exp_bits.delete();
    rises.delete();
    src_q.delete();
    dec_act   = 1'b0;
    hs_pend   = 1'b0;
    hs_cnt    = 0;
    rdy_cnt   = 0;
    rdy_first = -1;
    done_cnt  = 0;
    done_cyc  = -1;
    busy_fall = -1;
  endtask

  task automatic push_exp(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) exp_bits.push_back(b[i]);
  endtask

  task automatic push_byte(input logic [7:0] b, input logic last);
    src_t s;
    s.d = b;
    s.l = last;
    src_q.push_back(s);
    push_exp(b);
  endtask

  task automatic do_start();
    start = 1'b1;
    cycles(1);
    start = 1'b0;
`ifdef TAPE_CAS_LEADER_EN
    push_exp(8'h00);
    push_exp(8'h00);
    push_exp(8'hA5);
`endif
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n = 0;
    while (busy && n < bound) begin
      cycles(1);
      n++;
    end
    check({tag, "_idle"}, 32'(busy), 32'd0);
    cycles(2);
  endtask

  task automatic wait_rises(input string tag, input int k, input int bound);
    int n = 0;
    while (rises.size() < k && n < bound) begin
      cycles(1);
      n++;
    end
    check({tag, "_rises"}, 32'(rises.size() >= k), 32'd1);
  endtask

  task automatic interrupt_and_replay(input logic use_reset, input string tag);
    flush();
    do_start();
    push_byte(8'h5A, 1'b0);
    push_byte(8'h81, 1'b1);
    cycles(39);
    if (use_reset) begin
      reset = 1'b1;
      #1;
      check({tag, "_done"}, 32'(done), 32'd0);
    end else begin
      abort = 1'b1;
      cycles(1);
      abort = 1'b0;
    end
    check({tag, "_tape"}, 32'(tape), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_rdy"}, 32'(in_ready), 32'd0);
    if (use_reset) begin
      cycles(2);
      reset = 1'b0;
    end
    flush();
    cycles(300);
    check({tag, "_no_done"}, 32'(done_cnt), 32'd0);
    check({tag, "_no_cells"}, 32'(rises.size()), 32'd0);
    do_start();
    push_byte(8'h5A, 1'b0);
    push_byte(8'h81, 1'b1);
    wait_idle({tag, "_replay"}, 2000);
    check({tag, "_replay_bits_left"}, 32'(exp_bits.size()), 32'd0);
    check({tag, "_replay_cells"}, 32'(rises.size()), 32'(LC + 16));
    check({tag, "_replay_period"}, 32'(rises[LC+8] - rises[LC]), 32'(8 * BC + 1));
    check({tag, "_replay_done"}, 32'(done_cnt), 32'd1);
  endtask

  initial begin
    int r0, m_cyc;
    logic quiet_bad;

    // Reset values
    cycles(2);
    check("rst_tape", 32'(tape), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rdy", 32'(in_ready), 32'd0);
    reset = 1'b0;
    cycles(2);

    // Single byte 0x80: timing of cells, done and busy
    flush();
    do_start();
    push_byte(8'h80, 1'b1);
    wait_idle("t1", 2000);
    check("t1_bits_left", 32'(exp_bits.size()), 32'd0);
    check("t1_cells", 32'(rises.size()), 32'(LC + 8));
    for (int k = 1; k < 8; k++)
      check("t1_cell_spacing", 32'(rises[LC+k] - rises[LC]), 32'(BC * k));
    check("t1_done_cnt", 32'(done_cnt), 32'd1);
    check("t1_done_cyc", 32'(done_cyc), 32'(rises[LC] + 8 * BC - 1));
    check("t1_busy_fall", 32'(busy_fall), 32'(done_cyc + 1));
    check("t1_hs", 32'(hs_cnt), 32'd1);
    check("t1_rdy_cycles", 32'(rdy_cnt), 32'd1);

    // Two back-to-back bytes
    flush();
    do_start();
    push_byte(8'hA5, 1'b0);
    push_byte(8'h3C, 1'b1);
    wait_idle("t2", 2000);
    check("t2_bits_left", 32'(exp_bits.size()), 32'd0);
    check("t2_cells", 32'(rises.size()), 32'(LC + 16));
    check("t2_hs", 32'(hs_cnt), 32'd2);
    check("t2_rdy_cycles", 32'(rdy_cnt), 32'd2);
    check("t2_byte_period", 32'(rises[LC+8] - rises[LC]), 32'(8 * BC + 1));
    check("t2_done_cnt", 32'(done_cnt), 32'd1);

    // Motor drop inside the second cell of 0xFF
    flush();
    do_start();
    push_byte(8'hFF, 1'b1);
    wait_rises("t3", LC + 1, 2000);
    r0 = rises[LC];
    cycles(19);
    motor = 1'b0;
    quiet_bad = 1'b0;
    for (int i = 0; i < 80; i++) begin
      cycles(1);
      if (cyc > r0 + 2 * BC - 1) quiet_bad = quiet_bad | tape | !busy;
    end
    check("t3_pause_quiet", 32'(quiet_bad), 32'd0);
    check("t3_cells_at_pause", 32'(rises.size()), 32'(LC + 2));
    m_cyc = cyc;
    motor = 1'b1;
    wait_idle("t3", 2000);
    check("t3_cell1_full", 32'(rises[LC+1] - rises[LC]), 32'(BC));
    check("t3_resume", 32'(rises[LC+2]), 32'(m_cyc + 2));
    check("t3_cells", 32'(rises.size()), 32'(LC + 8));
    check("t3_bits_left", 32'(exp_bits.size()), 32'd0);
    check("t3_done_cnt", 32'(done_cnt), 32'd1);

    // Underrun between bytes
    flush();
    do_start();
    push_byte(8'h5A, 1'b0);
    begin
      int n = 0;
      while (!(hs_cnt >= 1 && in_ready) && n < 2000) begin
        cycles(1);
        n++;
      end
    end
    check("t4_back_in_fetch", 32'(in_ready), 32'd1);
    quiet_bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      cycles(1);
      quiet_bad = quiet_bad | tape | !busy | !in_ready;
    end
    check("t4_hold_fetch", 32'(quiet_bad), 32'd0);
    check("t4_hs_during_hold", 32'(hs_cnt), 32'd1);
    push_byte(8'hC3, 1'b1);
    wait_idle("t4", 2000);
    check("t4_bits_left", 32'(exp_bits.size()), 32'd0);
    check("t4_byte2_span", 32'(rises[LC+15] - rises[LC+8]), 32'(7 * BC));
    check("t4_hs", 32'(hs_cnt), 32'd2);
    check("t4_done_cnt", 32'(done_cnt), 32'd1);

    // Abort and reset mid-byte, then replay
    interrupt_and_replay(1'b0, "t5_abort");
    interrupt_and_replay(1'b1, "t5_reset");

    // Start together with abort resolves to abort
    flush();
    start = 1'b1;
    abort = 1'b1;
    cycles(1);
    start = 1'b0;
    abort = 1'b0;
    cycles(1);
    check("t5_start_abort_busy", 32'(busy), 32'd0);

`ifdef TAPE_CAS_LEADER_EN
    // Leader then data byte
    flush();
    do_start();
    push_byte(8'h55, 1'b1);
    wait_idle("t6", 3000);
    check("t6_bits_left", 32'(exp_bits.size()), 32'd0);
    check("t6_cells", 32'(rises.size()), 32'd32);
    check("t6_rdy_first", 32'(rdy_first), 32'(rises[0] + 24 * BC - 1));
    check("t6_done_cnt", 32'(done_cnt), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
